// File: rtl/uart_tx_arbiter.sv
// Per-byte round-robin arbiter sharing one UART transmitter among NREQ byte sources.
// Optional define UART_ARB_PRIO0_EN gives requester 0 fixed priority at arbitration.
module uart_tx_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned BUSY_WAIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   lock,
    input  logic [8*NREQ-1:0] data,
    output logic [NREQ-1:0]   ack,
    output logic              TxD_Start,
    output logic [7:0]        TxD_Data,
    input  logic              busy,
    output logic [2:0]        grant_id,
    output logic              active,
    output logic              err
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAIT_HI = 2'd1;
    localparam logic [1:0] WAIT_LO = 2'd2;

    logic [1:0]      state;
    logic [2:0]      ptr;
    logic [7:0]      cnt;
    logic [7:0]      req_ext;
    logic [7:0]      lock_ext;
    logic [7:0]      bytes [8];
    int unsigned     idx;
    logic [2:0]      win;
    logic [2:0]      launch_id;
    logic [NREQ-1:0] launch_onehot;
    logic [2:0]      ptr_after;
    logic            relaunch;
    logic            do_launch;

    // Widen to 8 so any 3-bit id indexes without range issues.
    always_comb begin
        req_ext  = '0;
        lock_ext = '0;
        req_ext[NREQ-1:0]  = req;
        lock_ext[NREQ-1:0] = lock;
        for (int i = 0; i < 8; i++) bytes[i] = '0;
        for (int i = 0; i < int'(NREQ); i++) bytes[i] = data[8*i +: 8];
    end

    // Scan downward so the nearest set request at or after ptr is kept last.
    always_comb begin
        idx = 0;
        win = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            idx = 32'(ptr) + unsigned'(i);
            if (idx >= NREQ) idx = idx - NREQ;
            if (req_ext[idx[2:0]]) win = idx[2:0];
        end
`ifdef UART_ARB_PRIO0_EN
        if (req[0]) win = '0;
`endif
    end

    always_comb begin
        relaunch  = (state == WAIT_LO) && !busy && lock_ext[grant_id] && req_ext[grant_id];
        do_launch = ((state == IDLE) && !busy && (|req)) || relaunch;
        launch_id = (state == IDLE) ? win : grant_id;
        launch_onehot = '0;
        for (int i = 0; i < int'(NREQ); i++) launch_onehot[i] = (launch_id == 3'(i));
    end

    always_comb begin
        ptr_after = (grant_id == 3'(NREQ - 1)) ? 3'd0 : grant_id + 3'd1;
`ifdef UART_ARB_PRIO0_EN
        if (grant_id == 3'd0) ptr_after = ptr;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            ack       <= '0;
            TxD_Start <= 1'b0;
            TxD_Data  <= '0;
            grant_id  <= '0;
            active    <= 1'b0;
            err       <= 1'b0;
        end else begin
            TxD_Start <= 1'b0;
            ack       <= '0;
            err       <= 1'b0;
            if (do_launch) begin
                TxD_Data  <= bytes[launch_id];
                TxD_Start <= 1'b1;
                ack       <= launch_onehot;
                grant_id  <= launch_id;
                active    <= 1'b1;
                cnt       <= '0;
                state     <= WAIT_HI;
            end else begin
                case (state)
                    WAIT_HI: begin
                        if (busy) begin
                            state <= WAIT_LO;
                        end else if (cnt == 8'(BUSY_WAIT - 1)) begin
                            err    <= 1'b1;
                            active <= 1'b0;
                            ptr    <= ptr_after;
                            state  <= IDLE;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    WAIT_LO: begin
                        if (!busy) begin
                            active <= 1'b0;
                            ptr    <= ptr_after;
                            state  <= IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed scenarios plus random traffic checked each cycle
// against a transaction-level model; honours UART_ARB_PRIO0_EN when defined.
module tb_uart_tx_arbiter;
    localparam int NREQ      = 4;
    localparam int BUSY_WAIT = 16;

    logic              clk  = 1'b0;
    logic              rst  = 1'b0;
    logic [NREQ-1:0]   req  = '0;
    logic [NREQ-1:0]   lock = '0;
    logic [8*NREQ-1:0] data = '0;
    logic              busy = 1'b0;
    logic [NREQ-1:0]   ack;
    logic              TxD_Start;
    logic [7:0]        TxD_Data;
    logic [2:0]        grant_id;
    logic              active;
    logic              err;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(.NREQ(NREQ), .BUSY_WAIT(BUSY_WAIT)) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock), .data(data), .ack(ack),
        .TxD_Start(TxD_Start), .TxD_Data(TxD_Data), .busy(busy), .grant_id(grant_id),
        .active(active), .err(err)
    );

    always #5 clk = ~clk;

    // Transmitter stand-in: busy rises tx_rise cycles after a start, holds tx_hold cycles.
    int tx_rise = 2;
    int tx_hold = 10;
    bit tx_dead = 1'b0;
    bit rnd_mode = 1'b0;
    int rise_cd = 0;
    int hold_cd = 0;
    initial forever begin
        @(posedge clk);
        #1;
        if (!rst) begin
            busy = 1'b0; rise_cd = 0; hold_cd = 0;
        end else if (TxD_Start) begin
            if (rnd_mode) begin
                tx_dead = ($urandom_range(0, 9) == 0);
                tx_rise = $urandom_range(1, 4);
                tx_hold = $urandom_range(1, 8);
            end
            busy = 1'b0; hold_cd = 0;
            rise_cd = tx_dead ? 0 : tx_rise;
        end else if (rise_cd > 0) begin
            rise_cd--;
            if (rise_cd == 0) begin busy = 1'b1; hold_cd = tx_hold; end
        end else if (hold_cd > 0) begin
            hold_cd--;
            if (hold_cd == 0) busy = 1'b0;
        end else if (rnd_mode) begin
            if (busy) busy = ($urandom_range(0, 1) == 1);
            else if ($urandom_range(0, 29) == 0) busy = 1'b1;
        end
    end

    // Reference model: phase 0 = free, 1 = byte launched awaiting busy, 2 = byte on the wire.
    logic [NREQ-1:0] e_ack;
    logic            e_start;
    logic [7:0]      e_data;
    logic [2:0]      e_gid;
    logic            e_active;
    logic            e_err;
    int m_phase, m_ptr, m_age;

    task automatic m_reset();
        e_ack = '0; e_start = 0; e_data = '0; e_gid = '0; e_active = 0; e_err = 0;
        m_phase = 0; m_ptr = 0; m_age = 0;
    endtask

    function automatic int m_pick();
`ifdef UART_ARB_PRIO0_EN
        if (req[0]) return 0;
`endif
        for (int k = 0; k < NREQ; k++)
            if (req[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        return 0;
    endfunction

    task automatic m_launch(input int w);
        e_start = 1'b1;
        e_ack = '0;
        e_ack[w] = 1'b1;
        e_data = data[8*w +: 8];
        e_gid = 3'(w);
        e_active = 1'b1;
        m_age = 0;
        m_phase = 1;
    endtask

    task automatic m_release();
        e_active = 1'b0;
        m_phase = 0;
`ifdef UART_ARB_PRIO0_EN
        if (e_gid != 0) m_ptr = (int'(e_gid) + 1) % NREQ;
`else
        m_ptr = (int'(e_gid) + 1) % NREQ;
`endif
    endtask

    task automatic m_step();
        e_start = 1'b0; e_ack = '0; e_err = 1'b0;
        if (m_phase == 0) begin
            if (!busy && req != 0) m_launch(m_pick());
        end else if (m_phase == 1) begin
            m_age++;
            if (busy) m_phase = 2;
            else if (m_age == BUSY_WAIT) begin e_err = 1'b1; m_release(); end
        end else if (!busy) begin
            if (lock[e_gid] && req[e_gid]) m_launch(int'(e_gid));
            else m_release();
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) m_reset();
            else m_step();
        end
    end

    initial forever begin
        @(negedge clk);
        checks++;
        if (ack !== e_ack || TxD_Start !== e_start || TxD_Data !== e_data ||
            grant_id !== e_gid || active !== e_active || err !== e_err) begin
            errors++;
            $display("FAIL model_cycle t=%0t got ack=%b start=%b data=%h gid=%0d act=%b err=%b want ack=%b start=%b data=%h gid=%0d act=%b err=%b",
                     $time, ack, TxD_Start, TxD_Data, grant_id, active, err,
                     e_ack, e_start, e_data, e_gid, e_active, e_err);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic wait_start(input int limit, input string name);
        int n = 0;
        while (!TxD_Start && n < limit) begin tick(); n++; end
        chk(name, 32'(TxD_Start), 1);
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while ((active || busy) && n < limit) begin tick(); n++; end
        chk("return to idle", 32'(active), 0);
        tick();
    endtask

`ifdef UART_ARB_PRIO0_EN
    int exp_rr[5] = '{0, 0, 0, 0, 0};
`else
    int exp_rr[5] = '{0, 1, 2, 3, 0};
`endif
    int exp_lk[4] = '{1, 1, 1, 0};
    int got[5];
    int nl, n, t, starts;
    logic prev;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        repeat (3) tick();
        chk("reset outputs", {ack, TxD_Start, TxD_Data, grant_id, active, err}, 0);
        rst = 1'b1;
        tick();

        // Single byte from requester 2
        tx_rise = 2; tx_hold = 10;
        data[23:16] = 8'hA5; req = 4'b0100;
        tick();
        chk("single start", 32'(TxD_Start), 1);
        chk("single ack", 32'(ack), 32'h4);
        chk("single data", 32'(TxD_Data), 32'hA5);
        chk("single gid", 32'(grant_id), 2);
        chk("single active", 32'(active), 1);
        req = '0;
        tick();
        chk("single start drop", {ack, TxD_Start}, 0);
        chk("single data held", 32'(TxD_Data), 32'hA5);
        n = 0; prev = busy;
        while (!(prev && !busy) && n < 40) begin prev = busy; tick(); n++; end
        chk("single busy fell", 32'(prev && !busy), 1);
        chk("active at busy fall", 32'(active), 1);
        tick();
        chk("active after busy fall", 32'(active), 0);
        tick();

        // Reset while the byte is on the wire
        data[15:8] = 8'h5A; req = 4'b0010;
        wait_start(10, "reset-test launch");
        req = '0;
        n = 0;
        while (!busy && n < 20) begin tick(); n++; end
        tick(); tick();
        #1 rst = 1'b0;
        #2;
        chk("async reset outputs", {ack, TxD_Start, TxD_Data, grant_id, active, err}, 0);
        tick();
        rst = 1'b1;
        starts = 0;
        repeat (5) begin tick(); if (TxD_Start) starts++; end
        chk("no start after reset", starts, 0);

        // Round robin with all requesters held high
        tx_rise = 1; tx_hold = 3;
        data = {8'h13, 8'h12, 8'h11, 8'h10}; req = 4'b1111;
        nl = 0; n = 0;
        while (nl < 5 && n < 300) begin
            tick(); n++;
            if (TxD_Start) begin
                got[nl] = int'(grant_id);
                chk("rr ack", 32'(ack), 32'(1) << exp_rr[nl]);
                chk("rr data", 32'(TxD_Data), 32'h10 + 32'(exp_rr[nl]));
                nl++;
            end
        end
        req = '0;
        chk("rr launches", nl, 5);
        for (int k = 0; k < 5; k++) chk("rr order", got[k], exp_rr[k]);
        wait_idle(50);

        // Lock: requester 1 keeps the grant for three bytes, then 0 is served
        data[15:8] = 8'h21; data[7:0] = 8'h30;
        req = 4'b0010; lock = 4'b0010;
        nl = 0; n = 0;
        while (nl < 4 && n < 400) begin
            tick(); n++;
            if (TxD_Start) begin
                got[nl] = int'(grant_id);
                nl++;
                if (nl == 1) req[0] = 1'b1;
                if (nl == 3) begin lock[1] = 1'b0; req[1] = 1'b0; end
                if (nl == 4) req[0] = 1'b0;
            end
        end
        req = '0; lock = '0;
        chk("lock launches", nl, 4);
        for (int k = 0; k < 4; k++) chk("lock order", got[k], exp_lk[k]);
        wait_idle(50);

        // Busy timeout
        data[15:8] = 8'h41; data[23:16] = 8'h42;
        tx_dead = 1'b1; req = 4'b0110;
        wait_start(20, "timeout launch");
        chk("timeout gid", 32'(grant_id), 1);
        req[1] = 1'b0; tx_dead = 1'b0;
        t = 0;
        while (!err && t < 40) begin tick(); t++; end
        chk("timeout latency", t, BUSY_WAIT);
        chk("timeout active", 32'(active), 0);
        tick();
        chk("err one cycle", 32'(err), 0);
        wait_start(20, "after-timeout launch");
        chk("after-timeout gid", 32'(grant_id), 2);
        chk("after-timeout data", 32'(TxD_Data), 32'h42);
        req = '0;
        wait_idle(50);

`ifdef UART_ARB_PRIO0_EN
        // Requester 0 overrides the round-robin pointer
        rst = 1'b0; tick(); rst = 1'b1; tick();
        data = {8'h53, 8'h52, 8'h51, 8'h50}; req = 4'b0100;
        wait_start(10, "prio first launch");
        chk("prio first gid", 32'(grant_id), 2);
        req = 4'b1110;
        tick();
        req = 4'b1111;
        wait_start(60, "prio second launch");
        chk("prio second gid", 32'(grant_id), 0);
        req = '0;
        wait_idle(50);
`endif

        // Random traffic, checked every cycle by the model
        rnd_mode = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            tick();
            if (c == 2000) begin #1 rst = 1'b0; #2 rst = 1'b1; end
            for (int i = 0; i < NREQ; i++) begin
                if (ack[i]) begin
                    if ($urandom_range(0, 2) != 0) data[8*i +: 8] = 8'($urandom);
                    else req[i] = 1'b0;
                end else if (!req[i]) begin
                    if ($urandom_range(0, 5) == 0) begin
                        req[i] = 1'b1;
                        data[8*i +: 8] = 8'($urandom);
                    end
                end else if ($urandom_range(0, 60) == 0) begin
                    req[i] = 1'b0;
                end
                lock[i] = ($urandom_range(0, 2) == 0);
            end
        end
        rnd_mode = 1'b0;
        req = '0; lock = '0;
        wait_idle(100);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
